// File: rtl/bus_permute_pipe_if.sv
// Bundled config port and data streams of bus_permute_pipe.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload until then.
interface bus_permute_pipe_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
);
  logic             cfg_valid;
  logic [IDXW-1:0]  cfg_dst;
  logic [IDXW-1:0]  cfg_src;
  logic             cfg_commit;
  logic             cfg_ready;
  logic             cfg_err;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output cfg_valid, cfg_dst, cfg_src, cfg_commit, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_valid, cfg_dst, cfg_src, cfg_commit, in_valid, in_data, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bus_permute_pipe.sv
// Registered bit permutation: out_data[i] = in_data[active_map[i]], with a shadow map
// that is swapped in only once the output register has drained.
module bus_permute_pipe #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_permute_pipe_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

  localparam logic [IDXW:0] LP_WIDTH = (IDXW + 1)'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDXW-1:0]  r_shadow [WIDTH];
  logic [IDXW-1:0]  r_active [WIDTH];
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_perm;
  logic             r_out_valid;
  logic             r_cfg_err;
  logic             w_in_ready;
  logic             w_cfg_ready;
  logic             w_swap;
  logic             w_in_fire;
  logic             w_cfg_fire;
  logic             w_cfg_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_cfg_ready = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_cfg_ready = 1'b1;
        w_in_ready  = !r_out_valid || bus.out_ready;
        if (bus.cfg_commit) w_state_nxt = S_DRAIN;
      end
      // Wait for a cycle that starts with an empty output register.
      S_DRAIN: if (!r_out_valid) w_state_nxt = S_SWAP;
      S_SWAP: begin
        w_swap      = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_cfg_fire = bus.cfg_valid && w_cfg_ready;
  assign w_cfg_ok   = ({1'b0, bus.cfg_dst} < LP_WIDTH) && ({1'b0, bus.cfg_src} < LP_WIDTH);

  always_comb begin
    w_perm = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_perm[i] = bus.in_data[r_active[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cfg_err   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_shadow[i] <= IDXW'(i);
        r_active[i] <= IDXW'(i);
      end
    end else begin
      r_state <= w_state_nxt;

      if (w_in_fire) begin
        r_out_data  <= w_perm;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Out-of-range writes are dropped so the shadow never holds an illegal index.
      if (w_cfg_fire) begin
        if (w_cfg_ok) r_shadow[bus.cfg_dst] <= bus.cfg_src;
        else          r_cfg_err <= 1'b1;
      end

      if (w_swap) begin
        for (int i = 0; i < WIDTH; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_cfg_err <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_bus_permute_pipe.sv
// Directed bench for bus_permute_pipe: a WIDTH=4 instance for the map/commit behaviour
// and a WIDTH=5 instance for out-of-range config writes.
module tb_bus_permute_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_permute_pipe_if #(.WIDTH(4), .IDXW(2)) if4 ();
  bus_permute_pipe_if #(.WIDTH(5), .IDXW(3)) if5 ();
  logic [1:0] dbg4;
  logic [1:0] dbg5;

  bus_permute_pipe #(.WIDTH(4), .IDXW(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .o_dbg_state(dbg4)
  );
  bus_permute_pipe #(.WIDTH(5), .IDXW(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5), .o_dbg_state(dbg5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [7:0] map;   // src index for dst i at bits [2i+1:2i]
    logic [3:0] din;
    logic [3:0] dout;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write4(input logic [1:0] dst, input logic [1:0] src, input logic commit);
    if4.cfg_valid  = 1'b1;
    if4.cfg_dst    = dst;
    if4.cfg_src    = src;
    if4.cfg_commit = commit;
    tick();
    if4.cfg_valid  = 1'b0;
    if4.cfg_commit = 1'b0;
  endtask

  task automatic wait_stall4(input string name, input int exp_cycles);
    int cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if4.in_ready) break;
      cnt++;
      check({name, "_no_accept"}, if4.out_valid, 1'b0);
    end
    check(name, cnt, exp_cycles);
    tick();
  endtask

  task automatic wait_stall5(input string name, input int exp_cycles);
    int cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if5.in_ready) break;
      cnt++;
    end
    check(name, cnt, exp_cycles);
    tick();
  endtask

  task automatic program_map4(input logic [7:0] map);
    logic [7:0] m;
    m = map;
    for (int d = 0; d < 4; d++) begin
      cfg_write4(2'(d), m[2*d +: 2], d == 3);
    end
    wait_stall4("commit_stall", 2);
  endtask

  task automatic send_beat4(input logic [3:0] din, input logic [3:0] exp);
    logic [4:0] e;
    if4.in_valid = 1'b1;
    if4.in_data  = din;
    exp_q.push_back({1'b0, exp});
    @(negedge clk);
    check("in_ready_run", if4.in_ready, 1'b1);
    tick();
    if4.in_valid = 1'b0;
    @(negedge clk);
    check("out_valid", if4.out_valid, 1'b1);
    e = exp_q.pop_front();
    check("out_data", if4.out_data, e[3:0]);
    tick();
  endtask

  task automatic send_beat5(input logic [4:0] din, input logic [4:0] exp);
    logic [4:0] e;
    if5.in_valid = 1'b1;
    if5.in_data  = din;
    exp_q.push_back(exp);
    tick();
    if5.in_valid = 1'b0;
    @(negedge clk);
    check("out_valid_w5", if5.out_valid, 1'b1);
    e = exp_q.pop_front();
    check("out_data_w5", if5.out_data, e);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur_map;
    logic [4:0] e;

    vecs[0] = '{8'hE4, 4'b1010, 4'b1010};  // identity
    vecs[1] = '{8'hE4, 4'b0110, 4'b0110};
    vecs[2] = '{8'h1B, 4'b0001, 4'b1000};  // reverse
    vecs[3] = '{8'h1B, 4'b1100, 4'b0011};
    vecs[4] = '{8'hD8, 4'b0100, 4'b0010};  // {3,1,2,0}
    vecs[5] = '{8'hD8, 4'b1010, 4'b1100};
    vecs[6] = '{8'h00, 4'b0001, 4'b1111};  // fan-out of bit 0
    vecs[7] = '{8'h00, 4'b1110, 4'b0000};

    rst_n = 1'b0;
    if4.cfg_valid = 1'b0; if4.cfg_dst = '0; if4.cfg_src = '0; if4.cfg_commit = 1'b0;
    if4.in_valid  = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
    if5.cfg_valid = 1'b0; if5.cfg_dst = '0; if5.cfg_src = '0; if5.cfg_commit = 1'b0;
    if5.in_valid  = 1'b0; if5.in_data = '0; if5.out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", if4.out_valid, 1'b0);
    check("rst_out_data", if4.out_data, 4'b0000);
    check("rst_cfg_err", if4.cfg_err, 1'b0);
    check("rst_cfg_ready", if4.cfg_ready, 1'b1);
    check("rst_in_ready", if4.in_ready, 1'b1);
    check("rst_state", dbg4, 2'd0);
    check("rst_cfg_err_w5", if5.cfg_err, 1'b0);
    tick();

    cur_map = 8'hE4;
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].map != cur_map) begin
        program_map4(vecs[v].map);
        cur_map = vecs[v].map;
      end
      send_beat4(vecs[v].din, vecs[v].dout);
    end
    check("cfg_err_clean", if4.cfg_err, 1'b0);

    // Backpressure across a commit: held beat keeps the fan-out map, next beat gets reverse.
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_data   = 4'b0001;
    tick();
    cfg_write4(2'd0, 2'd3, 1'b0);
    cfg_write4(2'd1, 2'd2, 1'b0);
    cfg_write4(2'd2, 2'd1, 1'b0);
    cfg_write4(2'd3, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", if4.out_valid, 1'b1);
      check("bp_hold_data", if4.out_data, 4'b1111);
      check("bp_in_ready", if4.in_ready, 1'b0);
      tick();
    end
    if4.out_ready = 1'b1;
    @(negedge clk);
    check("bp_old_map_data", if4.out_data, 4'b1111);
    check("bp_drain_in_ready", if4.in_ready, 1'b0);
    exp_q.push_back(5'b01000);
    tick();
    wait_stall4("bp_stall_after_release", 2);
    if4.in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_map_valid", if4.out_valid, 1'b1);
    e = exp_q.pop_front();
    check("bp_new_map_data", if4.out_data, e[3:0]);
    tick();

    // Out-of-range config writes on the WIDTH=5 instance.
    if5.cfg_valid = 1'b1; if5.cfg_dst = 3'd1; if5.cfg_src = 3'd5;
    tick();
    if5.cfg_valid = 1'b0;
    @(negedge clk);
    check("err_bad_src", if5.cfg_err, 1'b1);
    tick();
    if5.cfg_commit = 1'b1;
    tick();
    if5.cfg_commit = 1'b0;
    wait_stall5("w5_stall_a", 2);
    check("err_clear_a", if5.cfg_err, 1'b0);
    send_beat5(5'b00010, 5'b00010);

    if5.cfg_valid = 1'b1; if5.cfg_dst = 3'd0; if5.cfg_src = 3'd4;
    tick();
    if5.cfg_dst = 3'd6; if5.cfg_src = 3'd0;
    tick();
    if5.cfg_valid = 1'b0;
    @(negedge clk);
    check("err_bad_dst", if5.cfg_err, 1'b1);
    tick();
    if5.cfg_commit = 1'b1;
    tick();
    if5.cfg_commit = 1'b0;
    wait_stall5("w5_stall_b", 2);
    check("err_clear_b", if5.cfg_err, 1'b0);
    send_beat5(5'b10000, 5'b10001);
    send_beat5(5'b00001, 5'b00000);

    // Reset while draining: shadow (reverse) is lost, identity is back.
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b1;
    if4.in_data   = 4'b0011;
    tick();
    if4.in_valid   = 1'b0;
    if4.cfg_commit = 1'b1;
    tick();
    if4.cfg_commit = 1'b0;
    @(negedge clk);
    check("mid_drain_state", dbg4, 2'd1);
    check("mid_drain_data", if4.out_data, 4'b1100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if4.out_ready = 1'b1;
    @(negedge clk);
    check("drain_rst_out_valid", if4.out_valid, 1'b0);
    check("drain_rst_cfg_ready", if4.cfg_ready, 1'b1);
    check("drain_rst_in_ready", if4.in_ready, 1'b1);
    tick();
    send_beat4(4'b0001, 4'b0001);
    if4.cfg_commit = 1'b1;
    tick();
    if4.cfg_commit = 1'b0;
    wait_stall4("post_rst_commit_stall", 2);
    send_beat4(4'b0001, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
